// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 4-register bus window, TX FIFO, 8N1 serializer.
// Bus reads are combinational, writes take effect on the clock edge.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] BAUD_RST  = 16'd867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_data,
  input  logic        m_rnw,
  input  logic        m_sel,
  output logic [31:0] s_data,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [4:0]      r_cnt;
  logic            r_ovf;
  logic            r_en;
  logic [15:0]     r_baud;
  logic [15:0]     r_bcnt;
  logic [2:0]      r_nbit;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic            w_hit;
  logic [1:0]      w_idx;
  logic            w_wr;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic            w_clr;
  logic            w_start;
  logic            w_busy;
  logic [7:0]      w_head;
  logic            w_tx_n;
  logic [15:0]     w_bcnt_n;
  logic [2:0]      w_nbit_n;
  logic [7:0]      w_shift_n;
  logic            w_unused;

  assign w_hit      = m_sel && (m_addr[31:4] == BASE_ADDR[31:4]);
  assign w_idx      = m_addr[3:2];
  assign w_wr       = w_hit && !m_rnw;
  assign w_full     = (r_cnt == 5'(DEPTH));
  assign w_empty    = (r_cnt == 5'd0);
  assign w_push_req = w_wr && (w_idx == 2'd0);
  assign w_push     = w_push_req && !w_full;
  assign w_clr      = w_wr && (w_idx == 2'd3) && m_data[1];
  assign w_start    = r_en && !w_empty;
  assign w_busy     = (r_state != S_IDLE);
  assign w_head     = r_mem[r_rp];
  assign w_unused   = &{1'b0, m_addr[1:0], m_data[31:16]};

  assign tx  = r_tx;
  assign irq = r_en && w_empty && !w_busy;

  always_comb begin
    s_data = 32'h0;
    if (w_hit && m_rnw) begin
      unique case (w_idx)
        2'd1:    s_data = {23'd0, r_ovf, w_busy, w_empty, w_full, r_cnt};
        2'd2:    s_data = {16'd0, r_baud};
        2'd3:    s_data = {31'd0, r_en};
        default: s_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= m_data[7:0];
  end

  // a push seen against a full FIFO is lost even if a pop frees a slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= 5'd0;
      r_ovf  <= 1'b0;
      r_en   <= 1'b0;
      r_baud <= BAUD_RST;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + 5'(w_push) - 5'(w_pop);
      r_ovf <= (w_push_req && w_full) || (r_ovf && !w_clr);
      if (w_wr && (w_idx == 2'd2)) r_baud <= m_data[15:0];
      if (w_wr && (w_idx == 2'd3)) r_en <= m_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_bcnt  <= 16'd0;
      r_nbit  <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state_n;
      r_tx    <= w_tx_n;
      r_bcnt  <= w_bcnt_n;
      r_nbit  <= w_nbit_n;
      r_shift <= w_shift_n;
    end
  end

  // tx is computed one edge ahead so the line itself is a flop
  always_comb begin
    w_state_n = r_state;
    w_tx_n    = r_tx;
    w_bcnt_n  = r_bcnt;
    w_nbit_n  = r_nbit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        if (w_start) begin
          w_pop     = 1'b1;
          w_state_n = S_START;
          w_tx_n    = 1'b0;
          w_bcnt_n  = r_baud;
          w_shift_n = w_head;
        end
      end
      S_START: begin
        if (r_bcnt == 16'd0) begin
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
          w_bcnt_n  = r_baud;
          w_nbit_n  = 3'd0;
        end else begin
          w_bcnt_n = r_bcnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_bcnt == 16'd0) begin
          w_bcnt_n = r_baud;
          if (r_nbit == 3'd7) begin
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_nbit_n  = r_nbit + 3'd1;
            w_shift_n = {1'b0, r_shift[7:1]};
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_bcnt_n = r_bcnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_bcnt == 16'd0) begin
          if (w_start) begin
            w_pop     = 1'b1;
            w_state_n = S_START;
            w_tx_n    = 1'b0;
            w_bcnt_n  = r_baud;
            w_shift_n = w_head;
          end else begin
            w_state_n = S_IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_bcnt_n = r_bcnt - 16'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: bus register checks plus tx waveform
// compared against frames built from the queued bytes.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_TX = BASE;
  localparam logic [31:0] A_ST = BASE + 32'd4;
  localparam logic [31:0] A_BD = BASE + 32'd8;
  localparam logic [31:0] A_CT = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic        m_rnw = 1'b1;
  logic        m_sel = 1'b0;
  logic [31:0] s_data;
  logic        tx;
  logic        irq;

  int   checks = 0;
  int   failures = 0;
  logic rec = 1'b0;
  logic txlog[$];

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .m_addr (m_addr),
    .m_data (m_data),
    .m_rnw  (m_rnw),
    .m_sel  (m_sel),
    .s_data (s_data),
    .tx     (tx),
    .irq    (irq)
  );

  always @(negedge clk) if (rec) txlog.push_back(tx);

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    m_sel = 1'b1; m_rnw = 1'b0; m_addr = a; m_data = d;
    @(negedge clk);
    m_sel = 1'b0; m_rnw = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    m_sel = 1'b1; m_rnw = 1'b1; m_addr = a;
    #1 d = s_data;
    m_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] status_of(input int cnt, input bit ovf);
    return 32'(cnt) | ((cnt == 8) ? 32'h20 : 32'h0) |
           ((cnt == 0) ? 32'h40 : 32'h0) | (ovf ? 32'h100 : 32'h0);
  endfunction

  // Expected line: 8N1 frames of p clocks per bit, back to back, then idle.
  function automatic int wave_diff(input logic [7:0] bq[$], input int p);
    logic exp_q[$];
    logic [7:0] cur;
    int s;
    int d;
    d = 0;
    if (bq.size() == 0) begin
      foreach (txlog[i]) if (txlog[i] !== 1'b1) d++;
      return d;
    end
    foreach (bq[k]) begin
      cur = bq[k];
      for (int b = 0; b < 10; b++)
        for (int r = 0; r < p; r++)
          exp_q.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1]);
    end
    s = -1;
    foreach (txlog[i]) if (s < 0 && txlog[i] === 1'b0) s = i;
    if (s < 0) return 9999;
    if (s + exp_q.size() > txlog.size()) return 9998;
    foreach (exp_q[i]) if (txlog[s+i] !== exp_q[i]) d++;
    for (int i = s + exp_q.size(); i < txlog.size(); i++)
      if (txlog[i] !== 1'b1) d++;
    return d;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_lines tx=%b irq=%b want tx=1 irq=0", tx, irq);
    end
    bus_read(A_ST, v);
    checks++;
    if (v !== 32'h40) begin
      failures++; $display("FAIL reset_status got=%h want=%h", v, 32'h40);
    end
    bus_read(A_BD, v);
    checks++;
    if (v !== 32'h363) begin
      failures++; $display("FAIL reset_baud got=%h want=%h", v, 32'h363);
    end
    bus_read(A_CT, v);
    checks++;
    if (v !== 32'h0) begin
      failures++; $display("FAIL reset_ctrl got=%h want=0", v);
    end
    bus_read(A_TX, v);
    checks++;
    if (v !== 32'h0) begin
      failures++; $display("FAIL txdata_read got=%h want=0", v);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    bus_read(BASE + 32'h10, v);
    checks++;
    if (v !== 32'h0) begin
      failures++; $display("FAIL miss_read got=%h want=0", v);
    end
    m_sel = 1'b0; m_rnw = 1'b1; m_addr = A_BD;
    #1;
    checks++;
    if (s_data !== 32'h0) begin
      failures++; $display("FAIL nosel_read got=%h want=0", s_data);
    end
    m_rnw = 1'b0; m_data = 32'h5;
    @(negedge clk);
    m_rnw = 1'b1;
    bus_read(A_BD, v);
    checks++;
    if (v !== 32'h363) begin
      failures++; $display("FAIL nosel_write got=%h want=%h", v, 32'h363);
    end
    bus_write(A_BD + 32'd3, 32'hABCD_0012);
    bus_read(A_BD + 32'd1, v);
    checks++;
    if (v !== 32'h12) begin
      failures++; $display("FAIL baud_rw got=%h want=%h", v, 32'h12);
    end
  endtask

  task automatic test_a5();
    logic [31:0] v;
    logic [7:0] q[$];
    int d;
    bus_write(A_BD, 32'd3);
    bus_write(A_CT, 32'd1);
    txlog.delete(); rec = 1'b1;
    bus_write(A_TX, 32'hA5);
    idle(60);
    rec = 1'b0;
    q = '{8'hA5};
    d = wave_diff(q, 4);
    checks++;
    if (d !== 0) begin
      failures++; $display("FAIL a5_wave bad_samples=%0d want=0", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL a5_irq got=%b want=1", irq);
    end
    bus_read(A_ST, v);
    checks++;
    if (v !== 32'h40) begin
      failures++; $display("FAIL a5_status got=%h want=%h", v, 32'h40);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0] q[$];
    int d;
    bus_write(A_CT, 32'd0);
    bus_write(A_BD, 32'd1);
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'(i));
    bus_read(A_ST, v);
    checks++;
    if (v !== 32'h128) begin
      failures++; $display("FAIL ovf_status got=%h want=%h", v, 32'h128);
    end
    txlog.delete(); rec = 1'b1;
    bus_write(A_CT, 32'd3);
    bus_read(A_ST, v);
    checks++;
    if (v !== status_of(8, 1'b0)) begin
      failures++; $display("FAIL ovf_clear got=%h want=%h", v, status_of(8, 1'b0));
    end
    idle(190);
    rec = 1'b0;
    for (int i = 0; i < 8; i++) q.push_back(8'(i));
    d = wave_diff(q, 2);
    checks++;
    if (d !== 0) begin
      failures++; $display("FAIL ovf_wave bad_samples=%0d want=0", d);
    end
    bus_read(A_ST, v);
    checks++;
    if (v !== 32'h40 || irq !== 1'b1) begin
      failures++; $display("FAIL ovf_drained status=%h irq=%b want 40 irq=1", v, irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    int d;
    bus_write(A_CT, 32'd0);
    bus_write(A_BD, 32'd1);
    bus_write(A_TX, 32'h55);
    bus_write(A_TX, 32'h0F);
    txlog.delete(); rec = 1'b1;
    bus_write(A_CT, 32'd1);
    idle(60);
    rec = 1'b0;
    q = '{8'h55, 8'h0F};
    d = wave_diff(q, 2);
    checks++;
    if (d !== 0) begin
      failures++; $display("FAIL b2b_wave bad_samples=%0d want=0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [7:0] q[$];
    int baud;
    int n;
    int d;
    for (int it = 0; it < 4; it++) begin
      baud = $urandom_range(0, 4);
      n = $urandom_range(1, 8);
      q.delete();
      bus_write(A_CT, 32'd0);
      bus_write(A_BD, 32'(baud));
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        bus_write(A_TX, {24'd0, q[i]});
      end
      bus_read(A_ST, v);
      checks++;
      if (v !== status_of(n, 1'b0)) begin
        failures++;
        $display("FAIL rnd_status it=%0d got=%h want=%h", it, v, status_of(n, 1'b0));
      end
      txlog.delete(); rec = 1'b1;
      bus_write(A_CT, 32'd1);
      idle(n * 10 * (baud + 1) + 20);
      rec = 1'b0;
      d = wave_diff(q, baud + 1);
      checks++;
      if (d !== 0) begin
        failures++;
        $display("FAIL rnd_wave it=%0d baud=%0d n=%0d bad_samples=%0d", it, baud, n, d);
      end
    end
  endtask

  task automatic test_enable_midframe();
    logic [31:0] v;
    logic [7:0] b[3];
    logic [7:0] q[$];
    int d;
    bus_write(A_CT, 32'd0);
    bus_write(A_BD, 32'd2);
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      bus_write(A_TX, {24'd0, b[i]});
    end
    txlog.delete(); rec = 1'b1;
    bus_write(A_CT, 32'd1);
    idle(5);
    bus_write(A_CT, 32'd0);
    idle(120);
    rec = 1'b0;
    q = '{b[0]};
    d = wave_diff(q, 3);
    checks++;
    if (d !== 0) begin
      failures++; $display("FAIL en_mid_wave bad_samples=%0d want=0", d);
    end
    bus_read(A_ST, v);
    checks++;
    if (v !== status_of(2, 1'b0) || irq !== 1'b0) begin
      failures++; $display("FAIL en_mid_status got=%h irq=%b want=%h irq=0", v, irq, status_of(2, 1'b0));
    end
    txlog.delete(); rec = 1'b1;
    bus_write(A_CT, 32'd1);
    idle(90);
    rec = 1'b0;
    q = '{b[1], b[2]};
    d = wave_diff(q, 3);
    checks++;
    if (d !== 0) begin
      failures++; $display("FAIL en_resume_wave bad_samples=%0d want=0", d);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    logic [7:0] q[$];
    int d;
    bus_write(A_BD, 32'd3);
    bus_write(A_CT, 32'd1);
    bus_write(A_TX, {24'd0, 8'($urandom)});
    bus_write(A_TX, {24'd0, 8'($urandom)});
    idle(12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (tx !== 1'b1) begin
      failures++; $display("FAIL rst_mid_tx got=%b want=1", tx);
    end
    bus_read(A_ST, v);
    checks++;
    if (v !== 32'h40) begin
      failures++; $display("FAIL rst_mid_status got=%h want=%h", v, 32'h40);
    end
    bus_read(A_BD, v);
    checks++;
    if (v !== 32'd867) begin
      failures++; $display("FAIL rst_mid_baud got=%h want=%h", v, 32'd867);
    end
    txlog.delete(); rec = 1'b1;
    idle(100);
    rec = 1'b0;
    d = wave_diff(q, 4);
    checks++;
    if (d !== 0 || irq !== 1'b0) begin
      failures++; $display("FAIL rst_mid_quiet low_samples=%0d irq=%b want 0 irq=0", d, irq);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_decode();
    test_a5();
    test_overflow();
    test_back_to_back();
    test_random();
    test_enable_midframe();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, base of the 16-byte register window.
REQ-002 SHALL have parameter DEPTH, default 8, TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter BAUD_RST, default 16'd867, reset value of BAUDDIV.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port m_addr  input  32  bus byte address from the memory stage.
REQ-007 SHALL have port m_data  input  32  store data from the memory stage.
REQ-008 SHALL have port m_rnw  input  1  1 = read, 0 = write.
REQ-009 SHALL have port m_sel  input  1  peripheral-space select from the memory stage.
REQ-010 SHALL have port s_data  output  32  read data returned to the memory stage.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port irq  output  1  level interrupt, TX drained.

Function
REQ-013 SHALL define hit = m_sel and m_addr[31:4] == BASE_ADDR[31:4]; register index = m_addr[3:2]; m_addr[1:0] ignored.
REQ-014 SHALL drive s_data combinationally in the same cycle as a read hit; 32'h0 when no hit; reads have no side effects.
REQ-015 SHALL write on a clock edge with hit and m_rnw = 0; writes use all of m_data regardless of store width.
REQ-016 SHALL map index 0 TXDATA: write pushes m_data[7:0]; reads 0.
REQ-017 SHALL map index 1 STATUS (read-only): [4:0] FIFO count, [5] full, [6] empty, [7] busy (FSM not IDLE), [8] overflow sticky; other bits 0.
REQ-018 SHALL map index 2 BAUDDIV, R/W, bits [15:0]; bit period = BAUDDIV+1 clocks; upper bits read 0.
REQ-019 SHALL map index 3 CTRL: bit0 enable (R/W); bit1 write-1 clears overflow, reads 0.
REQ-020 SHALL accept a push only when the FIFO is not full at the start of the cycle; a push to a full FIFO is dropped and sets overflow, even if a pop occurs the same cycle.
REQ-021 SHALL leave count unchanged on a simultaneous accepted push and pop; a write-1 clear of overflow in the same cycle as a new overflow leaves overflow set.
REQ-022 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-023 IDLE: tx = 1; when enable = 1 and FIFO not empty, pop head into shift register, load bit counter with BAUDDIV, go START.
REQ-024 START: tx = 0 for one bit period; DATA: 8 bits LSB first, one bit period each; STOP: tx = 1 for one bit period.
REQ-025 SHALL reload the bit counter from current BAUDDIV at each bit start; a BAUDDIV write mid-bit affects only subsequent bits.
REQ-026 From STOP: pop next byte and go directly to START if enable = 1 and FIFO not empty, giving back-to-back frames of exactly 10 bit periods.
REQ-027 Clearing enable mid-frame SHALL let the current frame complete, then stay IDLE; FIFO contents are retained.
REQ-028 irq SHALL be 1 when enable = 1, FIFO empty and FSM IDLE; else 0.
REQ-029 tx SHALL be registered (no combinational path from bus inputs).

Reset
REQ-030 On clk edge with rst_n = 0: FSM IDLE, tx = 1, FIFO empty (count 0), overflow 0, enable 0, BAUDDIV = BAUD_RST, irq = 0.
REQ-031 Reset mid-frame SHALL abort the frame immediately, tx = 1 the following cycle, FIFO contents discarded.

Verification
REQ-032 BAUDDIV = 3, enable = 1, write 8'hA5 to TXDATA -> tx: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 clocks; 40 clocks total; irq returns 1.
REQ-033 enable = 0, 9 writes 0x00..0x08 (DEPTH = 8) -> STATUS reads 0x0000_0128 (count 8, full, overflow); write CTRL = 3 -> overflow 0; bytes 0x00..0x07 sent, 0x08 never sent.
REQ-034 Read BASE_ADDR+8 after reset -> s_data = 0x0000_0363; read BASE_ADDR+0x10 (miss) -> s_data = 0; m_sel = 0 with matching address -> no write, s_data = 0.
REQ-035 Queue 0x55, 0x0F with BAUDDIV = 1 -> two frames back-to-back, no idle gap, 40 clocks total.
REQ-036 Assert rst_n = 0 for one cycle during DATA of a frame -> next cycle tx = 1, STATUS = 0x0000_0040, BAUDDIV = 867, no further frame output.
